// File: rtl/rpsc_hv_sequencer.sv
// HV power sequencer for the G1 and anode supplies: ramps G1, then the anode,
// supervises both while running and latches the first fault cause until acknowledged.
module rpsc_hv_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       test_mode,
    input  logic       start_req,
    input  logic       stop_req,
    input  logic       fault_ack,
    input  logic       g1_alarm,
    input  logic       g1_ok,
    input  logic       an_alarm,
    input  logic       an_perm,
    input  logic       an_ok,
    output logic       g1_ps_act,
    output logic       an_ps_act,
    output logic       hv_on,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [2:0] state
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_G1_RAMP  = 3'd1;
    localparam logic [2:0] ST_G1_ON    = 3'd2;
    localparam logic [2:0] ST_AN_RAMP  = 3'd3;
    localparam logic [2:0] ST_HV_ON    = 3'd4;
    localparam logic [2:0] ST_SHUTDOWN = 3'd5;
    localparam logic [2:0] ST_FAULT    = 3'd6;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_G1_ALARM = 3'd1;
    localparam logic [2:0] FC_G1_TMO   = 3'd2;
    localparam logic [2:0] FC_AN_ALARM = 3'd3;
    localparam logic [2:0] FC_AN_TMO   = 3'd4;
    localparam logic [2:0] FC_G1_LOST  = 3'd5;
    localparam logic [2:0] FC_AN_LOST  = 3'd6;
    localparam logic [2:0] FC_ILLEGAL  = 3'd7;

    // Bit order of the synchronized input bus
    localparam int B_START = 7;
    localparam int B_STOP  = 6;
    localparam int B_ACK   = 5;
    localparam int B_G1A   = 4;
    localparam int B_G1OK  = 3;
    localparam int B_ANA   = 2;
    localparam int B_PERM  = 1;
    localparam int B_ANOK  = 0;

    logic [7:0]  raw_s;
    logic [7:0]  sync1_r;
    logic [7:0]  sync2_r;
    logic [2:0]  state_r;
    logic [2:0]  state_nx_s;
    logic [2:0]  cause_s;
    logic [21:0] timer_r;
    logic [21:0] g1_last_s;
    logic [21:0] perm_last_s;
    logic [21:0] an_last_s;
    logic [21:0] off_last_s;
    logic        g1_act_s;
    logic        an_act_s;
    logic        hv_on_s;
    logic        fault_s;
    logic        g1_act_r;
    logic        an_act_r;
    logic        hv_on_r;
    logic        fault_r;
    logic [2:0]  fault_code_r;

    logic s_start, s_stop, s_ack, s_g1a, s_g1ok, s_ana, s_perm, s_anok;

    assign raw_s = {start_req, stop_req, fault_ack, g1_alarm, g1_ok, an_alarm, an_perm, an_ok};

    assign s_start = sync2_r[B_START];
    assign s_stop  = sync2_r[B_STOP];
    assign s_ack   = sync2_r[B_ACK];
    assign s_g1a   = sync2_r[B_G1A];
    assign s_g1ok  = sync2_r[B_G1OK];
    assign s_ana   = sync2_r[B_ANA];
    assign s_perm  = sync2_r[B_PERM];
    assign s_anok  = sync2_r[B_ANOK];

    // Timer compare values are limit-1 so a timeout exits on the limit-th edge
    assign g1_last_s   = test_mode ? 22'd15 : 22'd2343749;
    assign perm_last_s = test_mode ? 22'd15 : 22'd2343749;
    assign an_last_s   = test_mode ? 22'd23 : 22'd3906249;
    assign off_last_s  = test_mode ? 22'd3  : 22'd781249;

    // Two-stage synchronizers for all level inputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r <= 8'd0;
            sync2_r <= 8'd0;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // State register and per-state timer
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            timer_r <= 22'd0;
        end else begin
            state_r <= state_nx_s;
            if (state_nx_s != state_r) begin
                timer_r <= 22'd0;
            end else if (timer_r != 22'h3FFFFF) begin
                timer_r <= timer_r + 22'd1;
            end else begin
                timer_r <= timer_r;
            end
        end
    end

    // Next-state logic; rows are checked in priority order so faults beat stop and stop beats start
    always_comb begin
        state_nx_s = state_r;
        cause_s    = FC_NONE;
        case (state_r)
            ST_IDLE: begin
                if (s_start && !s_stop && s_g1a) begin
                    state_nx_s = ST_FAULT;
                    cause_s    = FC_G1_ALARM;
                end else if (s_start && !s_stop) begin
                    state_nx_s = ST_G1_RAMP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_G1_RAMP: begin
                if (s_g1a) begin
                    state_nx_s = ST_FAULT;
                    cause_s    = FC_G1_ALARM;
                end else if (s_stop) begin
                    state_nx_s = ST_IDLE;
                end else if (s_g1ok) begin
                    state_nx_s = ST_G1_ON;
                end else if (timer_r == g1_last_s) begin
                    state_nx_s = ST_FAULT;
                    cause_s    = FC_G1_TMO;
                end else begin
                    state_nx_s = ST_G1_RAMP;
                end
            end
            ST_G1_ON: begin
                if (s_g1a) begin
                    state_nx_s = ST_FAULT;
                    cause_s    = FC_G1_ALARM;
                end else if (!s_g1ok) begin
                    state_nx_s = ST_FAULT;
                    cause_s    = FC_G1_LOST;
                end else if (s_stop) begin
                    state_nx_s = ST_IDLE;
                end else if (s_ana) begin
                    state_nx_s = ST_FAULT;
                    cause_s    = FC_AN_ALARM;
                end else if (s_perm) begin
                    state_nx_s = ST_AN_RAMP;
                end else if (timer_r == perm_last_s) begin
                    state_nx_s = ST_FAULT;
                    cause_s    = FC_AN_ALARM;
                end else begin
                    state_nx_s = ST_G1_ON;
                end
            end
            ST_AN_RAMP, ST_HV_ON: begin
                if (s_g1a) begin
                    state_nx_s = ST_FAULT;
                    cause_s    = FC_G1_ALARM;
                end else if (!s_g1ok) begin
                    state_nx_s = ST_FAULT;
                    cause_s    = FC_G1_LOST;
                end else if (s_ana || !s_perm) begin
                    state_nx_s = ST_FAULT;
                    cause_s    = FC_AN_ALARM;
                end else if ((state_r == ST_HV_ON) && !s_anok) begin
                    state_nx_s = ST_FAULT;
                    cause_s    = FC_AN_LOST;
                end else if (s_stop) begin
                    state_nx_s = ST_SHUTDOWN;
                end else if ((state_r == ST_AN_RAMP) && s_anok) begin
                    state_nx_s = ST_HV_ON;
                end else if ((state_r == ST_AN_RAMP) && (timer_r == an_last_s)) begin
                    state_nx_s = ST_FAULT;
                    cause_s    = FC_AN_TMO;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_SHUTDOWN: begin
                if (s_g1a) begin
                    state_nx_s = ST_FAULT;
                    cause_s    = FC_G1_ALARM;
                end else if (timer_r == off_last_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SHUTDOWN;
                end
            end
            ST_FAULT: begin
                if (s_ack && !s_g1a && !s_ana) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_FAULT;
                end
            end
            default: begin
                // Unreachable encoding: fall to the safe, de-energised fault state
                state_nx_s = ST_FAULT;
                cause_s    = FC_ILLEGAL;
            end
        endcase
    end

    // Output decode from the next state so outputs are valid in each state's first cycle
    always_comb begin
        g1_act_s = 1'b0;
        an_act_s = 1'b0;
        hv_on_s  = 1'b0;
        fault_s  = 1'b0;
        case (state_nx_s)
            ST_G1_RAMP, ST_G1_ON, ST_SHUTDOWN: begin
                g1_act_s = 1'b1;
            end
            ST_AN_RAMP: begin
                g1_act_s = 1'b1;
                an_act_s = 1'b1;
            end
            ST_HV_ON: begin
                g1_act_s = 1'b1;
                an_act_s = 1'b1;
                hv_on_s  = 1'b1;
            end
            ST_FAULT: begin
                fault_s = 1'b1;
            end
            default: begin
                g1_act_s = 1'b0;
            end
        endcase
    end

    // Output registers and first-fault latch
    always_ff @(posedge clk) begin
        if (!reset) begin
            g1_act_r     <= 1'b0;
            an_act_r     <= 1'b0;
            hv_on_r      <= 1'b0;
            fault_r      <= 1'b0;
            fault_code_r <= FC_NONE;
        end else begin
            g1_act_r <= g1_act_s;
            an_act_r <= an_act_s;
            hv_on_r  <= hv_on_s;
            fault_r  <= fault_s;
            if ((state_nx_s == ST_FAULT) && (state_r != ST_FAULT)) begin
                fault_code_r <= cause_s;
            end else if ((state_nx_s == ST_IDLE) && (state_r == ST_FAULT)) begin
                fault_code_r <= FC_NONE;
            end else begin
                fault_code_r <= fault_code_r;
            end
        end
    end

    assign g1_ps_act  = g1_act_r;
    assign an_ps_act  = an_act_r;
    assign hv_on      = hv_on_r;
    assign fault      = fault_r;
    assign fault_code = fault_code_r;
    assign state      = state_r;

endmodule

// File: tb/tb_rpsc_hv_sequencer.sv
// Directed plus randomized bench for rpsc_hv_sequencer, compared cycle by cycle
// against a rule-table reference model of the sequencer.
module tb_rpsc_hv_sequencer;

    logic       clk = 1'b0;
    logic       reset, test_mode;
    logic       start_req, stop_req, fault_ack;
    logic       g1_alarm, g1_ok, an_alarm, an_perm, an_ok;
    logic       g1_ps_act, an_ps_act, hv_on, fault;
    logic [2:0] fault_code, state;

    int checks = 0;
    int failures = 0;

    localparam int IDLE = 0, G1_RAMP = 1, G1_ON = 2, AN_RAMP = 3, HV_ON = 4, SHUTDOWN = 5, FAULT = 6;
    localparam int G1_TMO = 16, PERM_TMO = 16, AN_TMO = 24, AN_OFF_DLY = 4;

    // Reference model state: state, edges since entry, latched code, input history
    int         m_st = 0;
    int         m_age = 0;
    int         m_code = 0;
    logic [7:0] h0 = 8'd0;
    logic [7:0] h1 = 8'd0;

    always #5 clk = ~clk;

    rpsc_hv_sequencer dut (
        .clk(clk), .reset(reset), .test_mode(test_mode),
        .start_req(start_req), .stop_req(stop_req), .fault_ack(fault_ack),
        .g1_alarm(g1_alarm), .g1_ok(g1_ok), .an_alarm(an_alarm),
        .an_perm(an_perm), .an_ok(an_ok),
        .g1_ps_act(g1_ps_act), .an_ps_act(an_ps_act), .hv_on(hv_on),
        .fault(fault), .fault_code(fault_code), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fault rules in priority order; returns the code, or 0 when no fault fires
    function automatic int fault_cause(input int st, input logic [7:0] v, input int age);
        logic s, p, ga, gok, aa, pm, aok;
        {s, p, ga, gok, aa, pm, aok} = {v[7], v[6], v[4], v[3], v[2], v[1], v[0]};
        if (st == IDLE) return (s && !p && ga) ? 1 : 0;
        if (st == FAULT) return 0;
        if (ga) return 1;
        if ((st == G1_ON || st == AN_RAMP || st == HV_ON) && !gok) return 5;
        if ((st == AN_RAMP || st == HV_ON) && (aa || !pm)) return 3;
        if (st == HV_ON && !aok) return 6;
        if (p || st == SHUTDOWN) return 0;
        if (st == G1_RAMP && !gok && age == G1_TMO - 1) return 2;
        if (st == G1_ON && aa) return 3;
        if (st == G1_ON && !pm && age == PERM_TMO - 1) return 3;
        if (st == AN_RAMP && !aok && age == AN_TMO - 1) return 4;
        return 0;
    endfunction

    // Non-fault progression of the sequence
    function automatic int move(input int st, input logic [7:0] v, input int age);
        case (st)
            IDLE:     return (v[7] && !v[6]) ? G1_RAMP : IDLE;
            G1_RAMP:  return v[6] ? IDLE : (v[3] ? G1_ON : G1_RAMP);
            G1_ON:    return v[6] ? IDLE : (v[1] ? AN_RAMP : G1_ON);
            AN_RAMP:  return v[6] ? SHUTDOWN : (v[0] ? HV_ON : AN_RAMP);
            HV_ON:    return v[6] ? SHUTDOWN : HV_ON;
            SHUTDOWN: return (age == AN_OFF_DLY - 1) ? IDLE : SHUTDOWN;
            FAULT:    return (v[5] && !v[4] && !v[2]) ? IDLE : FAULT;
            default:  return IDLE;
        endcase
    endfunction

    task automatic model_edge();
        logic [7:0] v;
        int cause, nxt;
        if (!reset) begin
            h0 = 8'd0; h1 = 8'd0; m_st = IDLE; m_age = 0; m_code = 0;
        end else begin
            v  = h1;
            h1 = h0;
            h0 = {start_req, stop_req, fault_ack, g1_alarm, g1_ok, an_alarm, an_perm, an_ok};
            cause = fault_cause(m_st, v, m_age);
            nxt   = (cause != 0) ? FAULT : move(m_st, v, m_age);
            if (nxt != m_st) begin
                if (nxt == FAULT) m_code = cause;
                else if (m_st == FAULT) m_code = 0;
                m_age = 0;
                m_st  = nxt;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic tick();
        logic [9:0] exp_v, obs_v;
        @(posedge clk);
        model_edge();
        #1;
        exp_v = {(m_st >= 1 && m_st <= 5), (m_st == 3 || m_st == 4), (m_st == 4), (m_st == 6),
                 m_code[2:0], m_st[2:0]};
        obs_v = {g1_ps_act, an_ps_act, hv_on, fault, fault_code, state};
        chk("lockstep", {22'd0, obs_v}, {22'd0, exp_v});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_state(input int target, input int budget, input string tag);
        int ok = 0;
        for (int i = 0; i < budget && ok == 0; i++) begin
            tick();
            if (state == target[2:0]) ok = 1;
        end
        chk(tag, ok, 1);
    endtask

    initial begin
        reset = 1'b0; test_mode = 1'b1;
        start_req = 1'b0; stop_req = 1'b0; fault_ack = 1'b0;
        g1_alarm = 1'b0; g1_ok = 1'b0; an_alarm = 1'b0; an_perm = 1'b0; an_ok = 1'b0;
        ticks(2);
        chk("reset_state", state, 0);
        chk("reset_outs", {g1_ps_act, an_ps_act, hv_on, fault, fault_code}, 0);

        // Nominal power-up
        reset = 1'b1; start_req = 1'b1;
        ticks(2);
        chk("g1_before_3", g1_ps_act, 0);
        tick();
        chk("g1_at_3", g1_ps_act, 1);
        chk("st_g1_ramp", state, G1_RAMP);
        ticks(2);
        g1_ok = 1'b1;
        ticks(3);
        chk("st_g1_on", state, G1_ON);
        an_perm = 1'b1;
        ticks(2);
        chk("an_before_3", an_ps_act, 0);
        tick();
        chk("an_at_3", an_ps_act, 1);
        chk("st_an_ramp", state, AN_RAMP);
        ticks(6);
        an_ok = 1'b1;
        ticks(3);
        chk("st_hv_on", state, HV_ON);
        chk("hv_on", hv_on, 1);
        chk("code_nominal", fault_code, 0);

        // Orderly stop
        start_req = 1'b0; stop_req = 1'b1;
        ticks(3);
        chk("st_shutdown", state, SHUTDOWN);
        chk("shut_acts", {g1_ps_act, an_ps_act}, 2'b10);
        ticks(3);
        chk("g1_held_shut", g1_ps_act, 1);
        tick();
        chk("st_idle_after_shut", state, IDLE);
        chk("g1_off_after_shut", g1_ps_act, 0);

        // Stop beats start in IDLE
        start_req = 1'b1;
        ticks(5);
        chk("start_stop_idle", state, IDLE);

        // Anode alarm in HV_ON, ack blocked while alarm active
        stop_req = 1'b0;
        wait_state(HV_ON, 20, "reach_hv_on");
        an_alarm = 1'b1;
        ticks(3);
        chk("st_fault_an", state, FAULT);
        chk("code_an_alarm", fault_code, 3);
        chk("acts_off_fault", {g1_ps_act, an_ps_act}, 0);
        fault_ack = 1'b1;
        ticks(5);
        chk("ack_blocked", state, FAULT);
        start_req = 1'b0; an_alarm = 1'b0;
        ticks(3);
        chk("ack_clears", state, IDLE);
        chk("code_cleared", fault_code, 0);
        fault_ack = 1'b0;

        // G1 alarm and stop together in AN_RAMP
        an_ok = 1'b0; start_req = 1'b1;
        wait_state(AN_RAMP, 20, "reach_an_ramp");
        g1_alarm = 1'b1; stop_req = 1'b1;
        ticks(3);
        chk("prio_fault_st", state, FAULT);
        chk("prio_fault_code", fault_code, 1);
        g1_alarm = 1'b0; stop_req = 1'b0; start_req = 1'b0; fault_ack = 1'b1;
        wait_state(IDLE, 10, "clear_prio");
        fault_ack = 1'b0;

        // G1 timeout
        g1_ok = 1'b0; start_req = 1'b1;
        wait_state(G1_RAMP, 10, "reach_g1_ramp");
        ticks(15);
        chk("g1_tmo_edge15", state, G1_RAMP);
        tick();
        chk("g1_tmo_st", state, FAULT);
        chk("g1_tmo_code", fault_code, 2);
        chk("g1_tmo_acts", {g1_ps_act, an_ps_act}, 0);
        start_req = 1'b0; fault_ack = 1'b1; g1_ok = 1'b1;
        wait_state(IDLE, 10, "clear_g1_tmo");
        fault_ack = 1'b0;

        // Reset mid AN_RAMP
        start_req = 1'b1;
        wait_state(AN_RAMP, 20, "reach_an_ramp2");
        reset = 1'b0;
        tick();
        chk("reset_mid_st", state, IDLE);
        chk("reset_mid_outs", {g1_ps_act, an_ps_act, hv_on, fault, fault_code}, 0);
        reset = 1'b1;

        // Anode timeout
        wait_state(AN_RAMP, 20, "reach_an_ramp3");
        start_req = 1'b0;
        ticks(23);
        chk("an_tmo_edge23", state, AN_RAMP);
        tick();
        chk("an_tmo_st", state, FAULT);
        chk("an_tmo_code", fault_code, 4);
        fault_ack = 1'b1;
        wait_state(IDLE, 10, "clear_an_tmo");
        fault_ack = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                start_req = ($urandom_range(0, 9) < 7);
                stop_req  = ($urandom_range(0, 9) < 1);
                fault_ack = ($urandom_range(0, 9) < 3);
                g1_alarm  = ($urandom_range(0, 99) < 3);
                g1_ok     = ($urandom_range(0, 99) < 85);
                an_alarm  = ($urandom_range(0, 99) < 3);
                an_perm   = ($urandom_range(0, 99) < 85);
                an_ok     = ($urandom_range(0, 99) < 80);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
